l1_pulse_shaper: RTL and testbench
==================================

// Module: l1_pulse_shaper
// PURPOSE
//  Per-channel L1 trigger conditioner between the TURF trigger processor TRIG outputs
//  and the L1_P/N LVDS drivers in SURF_infrastructure. Per channel: rising-edge detect,
//  programmable-width stretch, programmable holdoff (deadtime), mask.
//  Counts accepted and vetoed edges per REF interval, with a muxed readout.
// PARAMETERS
//  NCH      4   number of L1 channels
//  STR_W    4   stretch-length field width (pulse = stretch_i+1 cycles)
//  DEAD_W   8   holdoff field width (holdoff_i cycles of deadtime)
//  CNT_W    16  width of accepted/vetoed counters (saturating)
// PORTS
//  clk_i        in   1          trigger clock (clk250 domain); all logic on rising edge
//  rst_n_i      in   1          asynchronous, active-low reset
//  trig_i       in   NCH        raw L1 from trigger processor, synchronous to clk_i
//  mask_i       in   NCH        1 = channel masked (new edges ignored)
//  stretch_i    in   STR_W      output pulse length minus one
//  holdoff_i    in   DEAD_W     deadtime cycles after pulse end
//  ref_i        in   1          REF pulse, synchronous to clk_i; rising edge ends interval
//  cnt_sel_i    in   $clog2(NCH) channel select for readout
//  acc_cnt_o    out  CNT_W      latched accepted count of selected channel
//  veto_cnt_o   out  CNT_W      latched vetoed count of selected channel
//  l1_o         out  NCH        shaped L1 pulses to LVDS drivers (registered)
//  busy_o       out  NCH        1 while channel in ACTIVE or DEAD (registered)
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): all FSMs IDLE; l1_o=0, busy_o=0; trig_q=0, ref_q=0;
//    live and latched counters = 0, so acc_cnt_o = veto_cnt_o = 0.
//  - Edge detect: edge[c] = trig_i[c] & ~trig_q[c]; trig_q <= trig_i each cycle.
//    A level held high across reset release counts as one edge on the first clock.
//  - Per-channel FSM, states IDLE / ACTIVE / DEAD, with a shared down-counter:
//    IDLE: edge & ~mask -> ACTIVE; cnt <= stretch_i; acc++ .
//          edge & mask -> ignored, not counted.
//    ACTIVE: l1_o=1. cnt==0 -> (holdoff_i==0 ? IDLE : DEAD with cnt<=holdoff_i-1);
//            else cnt--.
//    DEAD: l1_o=0. cnt==0 -> IDLE; else cnt--.
//  - Edge latency: edge sampled at clock k (FSM in IDLE) -> l1_o high from k for exactly
//    stretch_i+1 cycles, low for holdoff_i cycles, then re-armed.
//    An edge at the first IDLE cycle is accepted.
//  - stretch_i and holdoff_i are captured at pulse start/end; changes mid-pulse have no
//    effect on that pulse.
//  - Unmasked edge in ACTIVE or DEAD: veto++ (see L1_RETRIGGER_EN).
//    Mask change mid-pulse: no effect; the pulse in progress completes.
//  - busy_o = (state != IDLE), registered alongside l1_o.
//  - Counters: live acc/veto per channel saturate at 2^CNT_W-1 (no wrap).
//    On ref rise (ref_i & ~ref_q), all live counters copy to the latched bank and clear
//    in the same cycle. An edge in that same cycle is counted in the new interval
//    (live = 1), not the latched value.
//  - Readout: acc_cnt_o/veto_cnt_o = latched[cnt_sel_i], combinational mux of registers.
//    cnt_sel_i >= NCH returns 0.
//  - Channels are fully independent; simultaneous edges on all NCH channels all accepted.
// CONFIGURATION
//  L1_RETRIGGER_EN defined: unmasked edge in ACTIVE reloads cnt <= stretch_i, counts as
//    accepted, and extends the pulse (non-paralysable -> paralysable). Edge in DEAD is
//    still vetoed.
//  L1_RETRIGGER_EN undefined: edge in ACTIVE ignored for shaping and counted as vetoed.
// TESTING
//  1 Reset: hold rst_n_i=0, toggle trig_i -> l1_o=0, busy_o=0, counters 0;
//    release -> first clock idle.
//  2 stretch_i=3, holdoff_i=5, single 1-cycle trig_i[0] -> l1_o[0] high 4 cycles,
//    busy_o high 9 cycles; second edge 6 cycles later vetoed; ref -> acc=1, veto=1.
//  3 stretch_i=0, holdoff_i=0, trig_i[2] toggling every 2 cycles for 20 cycles ->
//    10 one-cycle pulses, acc=10, veto=0 after ref.
//  4 mask_i[1]=1, 5 edges on ch1 -> l1_o[1] never high, acc=veto=0;
//    mask asserted mid-pulse -> pulse completes full width.
//  5 ref rising edge coincident with accepted edge on ch3 -> latched acc excludes it,
//    next interval acc=1; saturate: 70000 edges with CNT_W=16 -> acc=65535.
//  6 L1_RETRIGGER_EN defined, stretch_i=3, edges 2 cycles apart x3 -> single l1_o pulse
//    of 8 cycles, acc=3, veto=0; undefined -> 4-cycle pulse, acc=1, veto=2
//    (holdoff_i=0).

Source files
------------

// File: rtl/l1_pulse_shaper.sv
// l1_pulse_shaper
//   Per-channel L1 trigger conditioner feeding the L1_P/N LVDS drivers.
//   Each channel detects rising edges on its raw trigger, stretches them to a
//   programmable width, applies a programmable deadtime, and honours a mask.
//   Accepted and vetoed edges are counted per REF interval; the counts of the
//   previous interval are held in a latched bank and read out through a mux.
//
//   Optional feature macro: L1_RETRIGGER_EN
//     defined   : an unmasked edge while the pulse is high reloads the stretch
//                 counter and is counted as accepted (paralysable extension)
//     undefined : an edge while the pulse is high is ignored and counted vetoed
//
// Ports
//   clk_i       trigger clock, all logic on the rising edge
//   rst_n_i     asynchronous active-low reset
//   trig_i      raw L1 per channel, synchronous to clk_i
//   mask_i      1 = channel masked, new edges ignored
//   stretch_i   output pulse length minus one
//   holdoff_i   deadtime cycles after the pulse ends
//   ref_i       REF pulse; its rising edge closes the counting interval
//   cnt_sel_i   channel select for the count readout
//   acc_cnt_o   latched accepted count of the selected channel
//   veto_cnt_o  latched vetoed count of the selected channel
//   l1_o        shaped L1 pulses (registered)
//   busy_o      channel is in ACTIVE or DEAD (registered)
//
// state  | meaning
// IDLE   | armed, waiting for an unmasked rising edge
// ACTIVE | l1_o high, counter runs down the stretch length
// DEAD   | l1_o low, counter runs down the holdoff; edges are vetoed

module l1_pulse_shaper #(
  parameter int NCH    = 4,
  parameter int STR_W  = 4,
  parameter int DEAD_W = 8,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NCH-1:0]    trig_i,
  input  logic [NCH-1:0]    mask_i,
  input  logic [STR_W-1:0]  stretch_i,
  input  logic [DEAD_W-1:0] holdoff_i,
  input  logic              ref_i,
  input  logic [SEL_W-1:0]  cnt_sel_i,
  output logic [CNT_W-1:0]  acc_cnt_o,
  output logic [CNT_W-1:0]  veto_cnt_o,
  output logic [NCH-1:0]    l1_o,
  output logic [NCH-1:0]    busy_o
);

  // One down-counter per channel serves both the stretch and holdoff phases.
  localparam int CW = (STR_W > DEAD_W) ? STR_W : DEAD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];

  logic [NCH-1:0] trig_q;
  logic [NCH-1:0] edge_det;
  logic [NCH-1:0] live_edge;
  logic [NCH-1:0] acc_inc;
  logic [NCH-1:0] veto_inc;
  logic [NCH-1:0] l1_d;
  logic [NCH-1:0] busy_d;
  logic           ref_q;
  logic           ref_rise;

  logic [CNT_W-1:0] acc_live  [NCH];
  logic [CNT_W-1:0] veto_live [NCH];
  logic [CNT_W-1:0] acc_lat   [NCH];
  logic [CNT_W-1:0] veto_lat  [NCH];

  assign edge_det  = trig_i & ~trig_q;
  assign live_edge = edge_det & ~mask_i;
  assign ref_rise  = ref_i & ~ref_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_q <= '0;
      ref_q  <= 1'b0;
      l1_o   <= '0;
      busy_o <= '0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      trig_q <= trig_i;
      ref_q  <= ref_i;
      l1_o   <= l1_d;
      busy_o <= busy_d;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  always_comb begin
    acc_inc  = '0;
    veto_inc = '0;
    l1_d     = '0;
    busy_d   = '0;
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        IDLE: begin
          if (live_edge[c]) begin
            state_d[c] = ACTIVE;
            cnt_d[c]   = CW'(stretch_i);
            acc_inc[c] = 1'b1;
          end
        end
        ACTIVE: begin
`ifdef L1_RETRIGGER_EN
          if (live_edge[c]) begin
            cnt_d[c]   = CW'(stretch_i);
            acc_inc[c] = 1'b1;
          end else if (cnt_q[c] == '0) begin
`else
          veto_inc[c] = live_edge[c];
          if (cnt_q[c] == '0) begin
`endif
            // Holdoff is sampled here, at the end of the pulse.
            if (holdoff_i == '0) begin
              state_d[c] = IDLE;
            end else begin
              state_d[c] = DEAD;
              cnt_d[c]   = CW'(holdoff_i - DEAD_W'(1));
            end
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
        DEAD: begin
          veto_inc[c] = live_edge[c];
          if (cnt_q[c] == '0) begin
            state_d[c] = IDLE;
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
        default: begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
        end
      endcase
      l1_d[c]   = (state_d[c] == ACTIVE);
      busy_d[c] = (state_d[c] != IDLE);
    end
  end

  // On a REF rise the live bank moves to the latched bank and restarts; an
  // edge in that same cycle belongs to the new interval.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < NCH; c++) begin
        acc_live[c]  <= '0;
        veto_live[c] <= '0;
        acc_lat[c]   <= '0;
        veto_lat[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ref_rise) begin
          acc_lat[c]   <= acc_live[c];
          veto_lat[c]  <= veto_live[c];
          acc_live[c]  <= CNT_W'(acc_inc[c]);
          veto_live[c] <= CNT_W'(veto_inc[c]);
        end else begin
          if (acc_inc[c] && (acc_live[c] != CNT_MAX)) begin
            acc_live[c] <= acc_live[c] + CNT_W'(1);
          end
          if (veto_inc[c] && (veto_live[c] != CNT_MAX)) begin
            veto_live[c] <= veto_live[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    acc_cnt_o  = '0;
    veto_cnt_o = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cnt_sel_i == SEL_W'(c)) begin
        acc_cnt_o  = acc_lat[c];
        veto_cnt_o = veto_lat[c];
      end
    end
  end

endmodule

// File: tb/tb_l1_pulse_shaper.sv
// Testbench for l1_pulse_shaper. The reference model describes each channel's
// pulse as a time window (start cycle, pulse-end cycle, re-arm cycle) and
// keeps the interval counts as plain integers.
module tb_l1_pulse_shaper;

  localparam int NCH    = 4;
  localparam int STR_W  = 4;
  localparam int DEAD_W = 8;
  localparam int CNT_W  = 10;   // narrowed so saturation is reachable quickly
  localparam int SEL_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n_i;
  logic [NCH-1:0]    trig_i;
  logic [NCH-1:0]    mask_i;
  logic [STR_W-1:0]  stretch_i;
  logic [DEAD_W-1:0] holdoff_i;
  logic              ref_i;
  logic [SEL_W-1:0]  cnt_sel_i;
  logic [CNT_W-1:0]  acc_cnt_o;
  logic [CNT_W-1:0]  veto_cnt_o;
  logic [NCH-1:0]    l1_o;
  logic [NCH-1:0]    busy_o;

  always #2 clk = ~clk;

  l1_pulse_shaper #(
    .NCH(NCH), .STR_W(STR_W), .DEAD_W(DEAD_W), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .trig_i(trig_i), .mask_i(mask_i),
    .stretch_i(stretch_i), .holdoff_i(holdoff_i), .ref_i(ref_i),
    .cnt_sel_i(cnt_sel_i), .acc_cnt_o(acc_cnt_o), .veto_cnt_o(veto_cnt_o),
    .l1_o(l1_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  int             m_n;
  int             m_start   [NCH];
  int             m_pend    [NCH];  // cycle at which the pulse ends and holdoff is sampled
  int             m_rearm   [NCH];  // first cycle an edge is accepted again
  int             m_acc     [NCH];
  int             m_veto    [NCH];
  int             m_acc_lat [NCH];
  int             m_veto_lat[NCH];
  bit [NCH-1:0]   m_prev;
  bit             m_ref_prev;
  bit [NCH-1:0]   m_l1;
  bit [NCH-1:0]   m_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_prev = '0;
    m_ref_prev = 1'b0;
    m_l1 = '0;
    m_busy = '0;
    for (int c = 0; c < NCH; c++) begin
      m_start[c] = -10; m_pend[c] = -10; m_rearm[c] = -10;
      m_acc[c] = 0; m_veto[c] = 0; m_acc_lat[c] = 0; m_veto_lat[c] = 0;
    end
  endtask

  task automatic model_step();
    int n;
    bit live, in_pulse, in_dead;
    int ia, iv;
    n = m_n;
    for (int c = 0; c < NCH; c++) begin
      live = trig_i[c] && !m_prev[c] && !mask_i[c];
      ia = 0; iv = 0;
      in_pulse = (n > m_start[c]) && (n <= m_pend[c]);
      in_dead  = !in_pulse && (n > m_pend[c]) && (n < m_rearm[c]);
      if (!in_pulse && !in_dead) begin
        if (live) begin
          m_start[c] = n;
          m_pend[c]  = n + int'(stretch_i) + 1;
          ia = 1;
        end
      end else if (in_pulse) begin
        if (live) begin
`ifdef L1_RETRIGGER_EN
          m_pend[c] = n + int'(stretch_i) + 1;
          ia = 1;
`else
          iv = 1;
`endif
        end
        if (n == m_pend[c]) m_rearm[c] = n + int'(holdoff_i) + 1;
      end else if (live) begin
        iv = 1;
      end
      m_l1[c]   = (m_start[c] <= n) && (n < m_pend[c]);
      m_busy[c] = m_l1[c] || ((n >= m_pend[c]) && (n < m_rearm[c] - 1));
      if (ref_i && !m_ref_prev) begin
        m_acc_lat[c]  = m_acc[c];
        m_veto_lat[c] = m_veto[c];
        m_acc[c]  = ia;
        m_veto[c] = iv;
      end else begin
        m_acc[c]  = (m_acc[c] + ia > CMAX) ? CMAX : m_acc[c] + ia;
        m_veto[c] = (m_veto[c] + iv > CMAX) ? CMAX : m_veto[c] + iv;
      end
    end
    m_prev = trig_i;
    m_ref_prev = ref_i;
    m_n = n + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("l1", 64'(l1_o), 64'(m_l1));
    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("acc_cnt", 64'(acc_cnt_o), 64'(m_acc_lat[cnt_sel_i]));
    chk("veto_cnt", 64'(veto_cnt_o), 64'(m_veto_lat[cnt_sel_i]));
  endtask

  task automatic drive(input logic [NCH-1:0] t, input logic r);
    trig_i = t;
    ref_i  = r;
    tick();
  endtask

  task automatic close_interval();
    drive('0, 1'b1);
    drive('0, 1'b0);
  endtask

  int w, b, rises;
  logic prev_l1;

  initial begin
    rst_n_i = 1'b0; trig_i = '0; mask_i = '0; ref_i = 1'b0; cnt_sel_i = '0;
    stretch_i = 4'd3; holdoff_i = 8'd5;
    model_reset();

    // reset: outputs stay quiet while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      trig_i = NCH'($urandom);
      ref_i = i[0];
      #1;
      chk("rst_l1", 64'(l1_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_acc", 64'(acc_cnt_o), 64'd0);
      chk("rst_veto", 64'(veto_cnt_o), 64'd0);
    end
    @(negedge clk);
    trig_i = 4'b0010; ref_i = 1'b0;
    rst_n_i = 1'b1;
    tick();
    chk("level_at_release", 64'(l1_o[1]), 64'd1);
    trig_i = '0;
    repeat (20) tick();
    close_interval();

    // single pulse, then an edge inside the deadtime
    stretch_i = 4'd3; holdoff_i = 8'd5; cnt_sel_i = 2'd0;
    w = 0; b = 0;
    for (int i = 0; i < 20; i++) begin
      drive((i == 0 || i == 6) ? 4'b0001 : 4'b0000, 1'b0);
      w += int'(l1_o[0]);
      b += int'(busy_o[0]);
    end
    chk("t2_width", 64'(w), 64'd4);
    chk("t2_busy", 64'(b), 64'd9);
    drive('0, 1'b1);
    chk("t2_acc", 64'(acc_cnt_o), 64'd1);
    chk("t2_veto", 64'(veto_cnt_o), 64'd1);
    drive('0, 1'b0);

    // zero stretch and holdoff, edge every 2 cycles
    stretch_i = 4'd0; holdoff_i = 8'd0; cnt_sel_i = 2'd2;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
      w += int'(l1_o[2]);
    end
    chk("t3_pulses", 64'(w), 64'd10);
    drive('0, 1'b0);
    drive('0, 1'b1);
    chk("t3_acc", 64'(acc_cnt_o), 64'd10);
    chk("t3_veto", 64'(veto_cnt_o), 64'd0);
    drive('0, 1'b0);

    // masked channel, then mask raised mid-pulse
    mask_i = 4'b0010; cnt_sel_i = 2'd1; stretch_i = 4'd2;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
      w += int'(l1_o[1]);
    end
    chk("t4_masked_l1", 64'(w), 64'd0);
    drive('0, 1'b1);
    chk("t4_acc", 64'(acc_cnt_o), 64'd0);
    chk("t4_veto", 64'(veto_cnt_o), 64'd0);
    drive('0, 1'b0);
    mask_i = '0; stretch_i = 4'd5; holdoff_i = 8'd2;
    w = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) mask_i = 4'b0010;
      drive((i == 0) ? 4'b0010 : 4'b0000, 1'b0);
      w += int'(l1_o[1]);
    end
    chk("t4_mid_mask_width", 64'(w), 64'd6);
    mask_i = '0;
    close_interval();

    // REF rise coincident with an accepted edge, then saturation
    stretch_i = 4'd0; holdoff_i = 8'd0; cnt_sel_i = 2'd3;
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b1000, 1'b1);
    chk("t5_lat_excl", 64'(acc_cnt_o), 64'd1);
    drive('0, 1'b0);
    drive('0, 1'b1);
    chk("t5_next_interval", 64'(acc_cnt_o), 64'd1);
    for (int i = 0; i < 1100; i++) begin
      drive(4'b1000, 1'b0);
      drive(4'b0000, 1'b0);
    end
    drive('0, 1'b1);
    chk("t5_saturate", 64'(acc_cnt_o), 64'(CMAX));
    chk("t5_sat_veto", 64'(veto_cnt_o), 64'd0);
    drive('0, 1'b0);

    // edges 2 cycles apart during a stretched pulse
    stretch_i = 4'd3; holdoff_i = 8'd0; cnt_sel_i = 2'd0;
    w = 0; rises = 0; prev_l1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive((i <= 4 && i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
      w += int'(l1_o[0]);
      if (l1_o[0] && !prev_l1) rises++;
      prev_l1 = l1_o[0];
    end
    drive('0, 1'b1);
    chk("t6_rises", 64'(rises), 64'd1);
`ifdef L1_RETRIGGER_EN
    chk("t6_width", 64'(w), 64'd8);
    chk("t6_acc", 64'(acc_cnt_o), 64'd3);
    chk("t6_veto", 64'(veto_cnt_o), 64'd0);
`else
    chk("t6_width", 64'(w), 64'd4);
    chk("t6_acc", 64'(acc_cnt_o), 64'd1);
    chk("t6_veto", 64'(veto_cnt_o), 64'd2);
`endif
    drive('0, 1'b0);

    // randomized traffic against the model, with one async reset midway
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_l1", 64'(l1_o), 64'd0);
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_acc", 64'(acc_cnt_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n_i = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) stretch_i = STR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) holdoff_i = DEAD_W'($urandom_range(0, 12));
      if ($urandom_range(0, 31) == 0) begin
        for (int c = 0; c < NCH; c++) mask_i[c] = ($urandom_range(0, 3) == 0);
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 2) == 0) trig_i[c] = ~trig_i[c];
      end
      ref_i = ($urandom_range(0, 39) == 0);
      cnt_sel_i = SEL_W'($urandom_range(0, NCH - 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
